adc_capture_sequencer: RTL and testbench

Sequences the capture of one six-channel ADC record into the shared single-port sample buffer and arbitrates that buffer between the capture writer, the Nios reader and the GUI reader. It sits between the ADC front end, the sample RAM, the Nios PIO handshake (writing-finish flag, read-new-sample acknowledge) and the VGA GUI read path. It replaces ad-hoc per-consumer RAM access with one owner.

---
 rtl/adc_capture_pkg.sv | 24 ++
 rtl/adc_capture_sequencer_edge_sync.sv | 22 ++
 rtl/adc_capture_sequencer.sv | 166 ++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared constants and types for the ADC capture sequencer.
package adc_capture_pkg;

  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NCH    = 6;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned SW     = NCH * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } cap_state_t;

  // Requester tag carried alongside a read through the RAM latency.
  typedef enum logic [1:0] {
    RID_NONE,
    RID_NIOS,
    RID_GUI
  } rd_id_t;

endpackage

// File: rtl/adc_capture_sequencer_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector (one-cycle pulse).
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic pulse_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= 3'b000;
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  // sh_q[1] is the synchronized level, sh_q[2] its previous value.
  assign pulse_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/adc_capture_sequencer.sv
// Captures one six-channel ADC record into the sample RAM and arbitrates the
// single RAM port between the capture writer, the Nios reader and the GUI reader.
module adc_capture_sequencer
  import adc_capture_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          take_sample,
  input  logic          sample_strobe,
  input  logic [SW-1:0] ch_data,
  input  logic          read_new_sample,
  input  logic          nios_rd_req,
  input  logic [AW-1:0] nios_rd_addr,
  input  logic          gui_rd_req,
  input  logic [AW-1:0] gui_rd_addr,
  output logic          nios_gnt,
  output logic          gui_gnt,
  output logic          nios_rd_valid,
  output logic          gui_rd_valid,
  output logic [SW-1:0] nios_rd_data,
  output logic [SW-1:0] gui_rd_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [SW-1:0] ram_wdata,
  input  logic [SW-1:0] ram_rdata,
  output logic          writing_finish_flag,
  output logic          busy,
  output logic [AW:0]   sample_count
);

  logic te, se, re;

  edge_sync u_take_sync (.clk(clk), .reset(reset), .d_i(take_sample),     .pulse_o(te));
  edge_sync u_strb_sync (.clk(clk), .reset(reset), .d_i(sample_strobe),   .pulse_o(se));
  edge_sync u_ack_sync  (.clk(clk), .reset(reset), .d_i(read_new_sample), .pulse_o(re));

  cap_state_t    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [SW-1:0] wdata_q, wdata_d;
  logic          ngnt_q, ngnt_d;
  logic          ggnt_q, ggnt_d;
  rd_id_t        tag_q, tag_d;
  logic          nval_q, nval_d;
  logic          gval_q, gval_d;
  logic [SW-1:0] ndata_q, ndata_d;
  logic [SW-1:0] gdata_q, gdata_d;
  logic          wr_fire;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    ngnt_d   = 1'b0;
    ggnt_d   = 1'b0;
    ndata_d  = ndata_q;
    gdata_d  = gdata_q;
    wr_fire  = se && ((state_q == S_ARMED) || (state_q == S_CAPTURE));

    // Read return: grant register -> tag stage (RAM access) -> valid/data.
    tag_d  = ngnt_q ? RID_NIOS : (ggnt_q ? RID_GUI : RID_NONE);
    nval_d = (tag_q == RID_NIOS);
    gval_d = (tag_q == RID_GUI);
    if (nval_d) ndata_d = ram_rdata;
    if (gval_d) gdata_d = ram_rdata;

    unique case (state_q)
      S_IDLE: begin
        if (te) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
          state_d  = S_ARMED;
        end
      end
      S_ARMED, S_CAPTURE: begin
        // wr_ptr is zero in ARMED, so word 0 aligns with the first fresh strobe.
        if (se) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q + (AW + 1)'(1);
          if (state_q == S_ARMED) begin
            state_d = S_CAPTURE;
          end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (re) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Fixed priority: capture write, Nios read (record complete only), GUI read.
    if (wr_fire) begin
      we_d    = 1'b1;
      addr_d  = wr_ptr_q;
      wdata_d = ch_data;
    end else if (nios_rd_req && (state_q == S_DONE)) begin
      ngnt_d = 1'b1;
      addr_d = nios_rd_addr;
    end else if (gui_rd_req) begin
      ggnt_d = 1'b1;
      addr_d = gui_rd_addr;
    end

    flag_d = (state_d == S_DONE);
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ngnt_q   <= 1'b0;
      ggnt_q   <= 1'b0;
      tag_q    <= RID_NONE;
      nval_q   <= 1'b0;
      gval_q   <= 1'b0;
      ndata_q  <= '0;
      gdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ngnt_q   <= ngnt_d;
      ggnt_q   <= ggnt_d;
      tag_q    <= tag_d;
      nval_q   <= nval_d;
      gval_q   <= gval_d;
      ndata_q  <= ndata_d;
      gdata_q  <= gdata_d;
    end
  end

  assign nios_gnt            = ngnt_q;
  assign gui_gnt             = ggnt_q;
  assign nios_rd_valid       = nval_q;
  assign gui_rd_valid        = gval_q;
  assign nios_rd_data        = ndata_q;
  assign gui_rd_data         = gdata_q;
  assign ram_addr            = addr_q;
  assign ram_we              = we_q;
  assign ram_wdata           = wdata_q;
  assign writing_finish_flag = flag_q;
  assign busy                = busy_q;
  assign sample_count        = cnt_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Scoreboard bench for adc_capture_sequencer with a behavioural sync RAM.
module tb_adc_capture_sequencer;
  import adc_capture_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          take_sample = 1'b0, sample_strobe = 1'b0, read_new_sample = 1'b0;
  logic [SW-1:0] ch_data = '0;
  logic          nios_rd_req = 1'b0, gui_rd_req = 1'b0;
  logic [AW-1:0] nios_rd_addr = '0, gui_rd_addr = '0;
  logic          nios_gnt, gui_gnt, nios_rd_valid, gui_rd_valid;
  logic [SW-1:0] nios_rd_data, gui_rd_data, ram_wdata;
  logic [SW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we, writing_finish_flag, busy;
  logic [AW:0]   sample_count;

  adc_capture_sequencer dut (
    .clk(clk), .reset(reset), .take_sample(take_sample), .sample_strobe(sample_strobe),
    .ch_data(ch_data), .read_new_sample(read_new_sample),
    .nios_rd_req(nios_rd_req), .nios_rd_addr(nios_rd_addr),
    .gui_rd_req(gui_rd_req), .gui_rd_addr(gui_rd_addr),
    .nios_gnt(nios_gnt), .gui_gnt(gui_gnt),
    .nios_rd_valid(nios_rd_valid), .gui_rd_valid(gui_rd_valid),
    .nios_rd_data(nios_rd_data), .gui_rd_data(gui_rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .writing_finish_flag(writing_finish_flag), .busy(busy), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency.
  logic [SW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int flag_rises = 0;
  int nval_seen = 0;
  logic flag_prev = 1'b0;
  logic [AW+SW-1:0] wq [$];
  logic [SW-1:0]    nq [$];
  logic [SW-1:0]    gq [$];
  int               gcyc [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every RAM write must match the next expected word.
  always @(negedge clk) begin
    if (ram_we) begin
      if (wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: addr %0d data %0h, no write expected", ram_addr, ram_wdata);
      end else begin
        chk("wr_word", 64'({ram_addr, ram_wdata}), 64'(wq.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (nios_rd_valid) begin
      nval_seen++;
      if (nq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL nios_rd_unexpected: data %0h, no read expected", nios_rd_data);
      end else begin
        chk("nios_rd_data", 64'(nios_rd_data), 64'(nq.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (gui_gnt) gcyc.push_back(cyc);
    if (gui_rd_valid) begin
      if (gq.size() == 0 || gcyc.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL gui_rd_unexpected: data %0h, no read expected", gui_rd_data);
      end else begin
        chk("gui_rd_data", 64'(gui_rd_data), 64'(gq.pop_front()));
        chk("gui_rd_latency", 64'(cyc - gcyc.pop_front()), 64'd2);
      end
    end
  end

  always @(negedge clk) begin
    if (writing_finish_flag && !flag_prev) flag_rises++;
    flag_prev = writing_finish_flag;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
    chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
    chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
    chk({tag, "_flag"}, 64'(writing_finish_flag), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_count"}, 64'(sample_count), 64'd0);
    chk({tag, "_nios_gnt"}, 64'(nios_gnt), 64'd0);
    chk({tag, "_gui_gnt"}, 64'(gui_gnt), 64'd0);
    chk({tag, "_nios_valid"}, 64'(nios_rd_valid), 64'd0);
    chk({tag, "_gui_valid"}, 64'(gui_rd_valid), 64'd0);
    chk({tag, "_nios_data"}, 64'(nios_rd_data), 64'd0);
    chk({tag, "_gui_data"}, 64'(gui_rd_data), 64'd0);
  endtask

  // One strobe: 2 cycles high, 2 low. Optionally collides a GUI read of word 3
  // with the capture write of this strobe.
  task automatic strobe(input logic [SW-1:0] d, input int a, input bit exp_wr, input bit collide);
    ch_data = d;
    sample_strobe = 1'b1;
    if (exp_wr) wq.push_back({AW'(a), d});
    cyc_wait(2);
    sample_strobe = 1'b0;
    if (collide) begin
      gui_rd_req  = 1'b1;
      gui_rd_addr = AW'(3);
      gq.push_back(SW'(3));
    end
    cyc_wait(1);
    if (collide) begin
      chk("collide_write_wins", 64'(ram_we), 64'd1);
      chk("collide_gui_blocked", 64'(gui_gnt), 64'd0);
    end
    cyc_wait(1);
    if (collide) begin
      chk("collide_gui_next", 64'(gui_gnt), 64'd1);
      gui_rd_req = 1'b0;
    end
  endtask

  task automatic pulse_re();
    read_new_sample = 1'b1;
    cyc_wait(2);
    read_new_sample = 1'b0;
    cyc_wait(4);
  endtask

  initial begin
    cyc_wait(3);
    check_all_zero("reset");
    reset = 1'b0;
    cyc_wait(2);

    pulse_re();
    chk("re_idle_busy", 64'(busy), 64'd0);
    chk("re_idle_flag", 64'(writing_finish_flag), 64'd0);

    take_sample = 1'b1;
    cyc_wait(6);
    chk("armed_busy", 64'(busy), 64'd1);
    take_sample = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      strobe(SW'(i), i, 1'b1, i == 50);
      if (i == 60) begin
        pulse_re();
        chk("re_capture_busy", 64'(busy), 64'd1);
      end
      if (i == 99) chk("count_100", 64'(sample_count), 64'd100);
    end
    cyc_wait(4);
    chk("done_flag", 64'(writing_finish_flag), 64'd1);
    chk("done_count", 64'(sample_count), 64'd4096);
    chk("done_busy", 64'(busy), 64'd0);
    chk("flag_rises", 64'(flag_rises), 64'd1);
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);

    // Nios outranks GUI while the record is complete.
    nios_rd_req = 1'b1; nios_rd_addr = AW'(5);
    gui_rd_req  = 1'b1; gui_rd_addr  = AW'(9);
    for (int k = 0; k < 6; k++) begin
      nq.push_back(SW'(5));
      cyc_wait(1);
      chk("done_nios_gnt", 64'(nios_gnt), 64'd1);
      chk("done_gui_starved", 64'(gui_gnt), 64'd0);
    end
    nios_rd_req = 1'b0;
    gq.push_back(SW'(9));
    cyc_wait(1);
    chk("gui_gnt_after_nios", 64'(gui_gnt), 64'd1);
    chk("nios_gnt_dropped", 64'(nios_gnt), 64'd0);
    gui_rd_req = 1'b0;
    cyc_wait(4);
    chk("nios_queue_drained", 64'(nq.size()), 64'd0);
    chk("gui_queue_drained", 64'(gq.size()), 64'd0);

    pulse_re();
    chk("re_done_flag", 64'(writing_finish_flag), 64'd0);
    chk("re_done_busy", 64'(busy), 64'd0);

    nios_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc_wait(1);
      chk("idle_nios_no_gnt", 64'(nios_gnt), 64'd0);
    end
    nios_rd_req = 1'b0;
    cyc_wait(3);
    chk("nios_valid_total", 64'(nval_seen), 64'd6);

    // Restart lands at word 0; then reset mid-record.
    take_sample = 1'b1;
    cyc_wait(6);
    take_sample = 1'b0;
    for (int i = 0; i < 100; i++) strobe({8'hA5, 40'(i)}, i, 1'b1, 1'b0);
    chk("restart_count_100", 64'(sample_count), 64'd100);
    reset = 1'b1;
    cyc_wait(1);
    check_all_zero("rst_mid");
    reset = 1'b0;
    cyc_wait(2);
    for (int i = 0; i < 3; i++) strobe({8'h5A, 40'(i)}, i, 1'b0, 1'b0);
    cyc_wait(2);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_count", 64'(sample_count), 64'd0);

    take_sample = 1'b1;
    cyc_wait(6);
    take_sample = 1'b0;
    for (int i = 0; i < 2; i++) strobe({8'h3C, 40'(i + 7)}, i, 1'b1, 1'b0);
    cyc_wait(2);
    chk("rearm_count", 64'(sample_count), 64'd2);
    chk("rearm_busy", 64'(busy), 64'd1);
    chk("final_wr_queue", 64'(wq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
